// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
//
// Samples the free-running output of a ripple counter, rejects the glitches
// it shows while its bits settle, and once per window emits how many counts
// went by since the previous window.
//
// Parameters:
//   WIDTH          width of the sampled count and of DELTA
//   STABLE_CYCLES  equal synchronised samples needed before FILT_COUNT moves (>=1)
//   PERIOD         window length in CLK cycles (>=2)
//
// Ports:
//   CLK         single clock, rising-edge
//   CLR         synchronous active-high reset, highest priority
//   COUNT_IN    ripple counter output, asynchronous to CLK
//   READY       downstream accepts DELTA when high together with VALID
//   VALID       DELTA holds an unconsumed result
//   DELTA       counts elapsed over the last window, modulo 2^WIDTH
//   FILT_COUNT  current deglitched count
//   OVERRUN     sticky: a window result was dropped under backpressure
//
// All outputs come straight from registers.
module ripple_count_monitor #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 2,
    parameter int PERIOD        = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] COUNT_IN,
    input  logic             READY,
    output logic             VALID,
    output logic [WIDTH-1:0] DELTA,
    output logic [WIDTH-1:0] FILT_COUNT,
    output logic             OVERRUN
);

    localparam int EQ_W  = $clog2(STABLE_CYCLES + 1);
    localparam int TMR_W = $clog2(PERIOD);

    localparam logic [EQ_W-1:0]  EQ_MAX   = EQ_W'(STABLE_CYCLES);
    localparam logic [EQ_W-1:0]  EQ_THR   = EQ_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);

    typedef enum logic {
        ST_FIRST,
        ST_RUN
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and deglitch filter
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] q1_reg;
    logic [WIDTH-1:0] q2_reg;
    logic [EQ_W-1:0]  eq_cnt_reg;
    logic [WIDTH-1:0] filt_reg;
    logic             samples_equal;

    assign samples_equal = (q1_reg == q2_reg);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            q1_reg     <= '0;
            q2_reg     <= '0;
            eq_cnt_reg <= '0;
            filt_reg   <= '0;
        end else begin
            q1_reg <= COUNT_IN;
            q2_reg <= q1_reg;
            if (samples_equal) begin
                if (eq_cnt_reg != EQ_MAX) begin
                    eq_cnt_reg <= eq_cnt_reg + 1'b1;
                end
                // The pre-edge eq_cnt already counts the earlier equal
                // edges, so this edge completes the run of STABLE_CYCLES.
                if (eq_cnt_reg >= EQ_THR) begin
                    filt_reg <= q2_reg;
                end
            end else begin
                eq_cnt_reg <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Window timer
    // ------------------------------------------------------------------
    logic [TMR_W-1:0] timer_reg;
    logic             tick;

    assign tick = (timer_reg == TMR_LAST);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            timer_reg <= '0;
        end else if (tick) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Window state machine and output slot
    // ------------------------------------------------------------------
    state_t           state_reg,    state_next;
    logic [WIDTH-1:0] baseline_reg, baseline_next;
    logic [WIDTH-1:0] delta_reg,    delta_next;
    logic             valid_reg,    valid_next;
    logic             overrun_reg,  overrun_next;
    logic [WIDTH-1:0] result;
    logic             accept;

    // Uses the pre-edge filtered count; a filter update on the tick edge
    // lands in the following window. Unsigned wrap gives the modulo.
    assign result = filt_reg - baseline_reg;
    assign accept = valid_reg && READY;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_reg    <= ST_FIRST;
            baseline_reg <= '0;
            delta_reg    <= '0;
            valid_reg    <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baseline_reg <= baseline_next;
            delta_reg    <= delta_next;
            valid_reg    <= valid_next;
            overrun_reg  <= overrun_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        baseline_next = baseline_reg;
        delta_next    = delta_reg;
        valid_next    = valid_reg;
        overrun_next  = overrun_reg;

        if (accept) begin
            valid_next = 1'b0;
        end

        if (tick) begin
            case (state_reg)
                ST_FIRST: begin
                    // No previous window yet: just record the starting point.
                    baseline_next = filt_reg;
                    state_next    = ST_RUN;
                end
                ST_RUN: begin
                    // Baseline advances even when the result is dropped so
                    // the next window still measures only its own counts.
                    baseline_next = filt_reg;
                    if (!valid_reg || accept) begin
                        delta_next = result;
                        valid_next = 1'b1;
                    end else begin
                        overrun_next = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_FIRST;
                end
            endcase
        end
    end

    assign VALID      = valid_reg;
    assign DELTA      = delta_reg;
    assign FILT_COUNT = filt_reg;
    assign OVERRUN    = overrun_reg;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Testbench for ripple_count_monitor (WIDTH=4, STABLE_CYCLES=2, PERIOD=16).
// Stimulus pushes each expected DELTA into a queue when it sets up the
// window; a monitor pops and compares on every VALID&&READY handshake.
// Status outputs (VALID, FILT_COUNT, OVERRUN) are checked directly.
module tb_ripple_count_monitor;

    localparam int W   = 4;
    localparam int PER = 16;

    logic         CLK = 1'b0;
    logic         CLR = 1'b1;
    logic [W-1:0] COUNT_IN = 4'd9;
    logic         READY = 1'b0;
    logic         VALID;
    logic [W-1:0] DELTA;
    logic [W-1:0] FILT_COUNT;
    logic         OVERRUN;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;
    int exp_q[$];

    ripple_count_monitor #(
        .WIDTH(W),
        .STABLE_CYCLES(2),
        .PERIOD(PER)
    ) dut (
        .CLK(CLK),
        .CLR(CLR),
        .COUNT_IN(COUNT_IN),
        .READY(READY),
        .VALID(VALID),
        .DELTA(DELTA),
        .FILT_COUNT(FILT_COUNT),
        .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    // Edges since the last CLR edge; ticks fall where this is a multiple of PER.
    always @(posedge CLK) begin
        if (CLR) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a handshake is visible between edges.
    always @(negedge CLK) begin
        if (!CLR && VALID && READY) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got delta=%0d expected none", DELTA);
            end else begin
                int e;
                e = exp_q.pop_front();
                $display("xfer t=%0t delta=%0d exp=%0d", $time, DELTA, e);
                check("delta", int'(DELTA), e);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Advance to just after the next edge whose edge count mod PER equals ph.
    task automatic goto_phase(input int ph);
        for (int i = 0; i < 2 * PER + 2; i++) begin
            @(posedge CLK);
            #1;
            if (edge_cnt % PER == ph) return;
        end
        check("phase_timeout", 1, 0);
    endtask

    task automatic goto_tick();
        goto_phase(0);
    endtask

    task automatic accept();
        READY = 1'b1;
        step(1);
        READY = 1'b0;
    endtask

    initial begin
        // Reset with a live count on the input.
        step(3);
        check("rst_valid",   int'(VALID), 0);
        check("rst_delta",   int'(DELTA), 0);
        check("rst_filt",    int'(FILT_COUNT), 0);
        check("rst_overrun", int'(OVERRUN), 0);
        CLR = 1'b0;
        step(2);
        check("filt_settling", int'(FILT_COUNT), 0);
        step(2);
        check("filt_after_rst", int'(FILT_COUNT), 9);

        // Basic rate: hold 3 from reset, first tick only sets the baseline.
        CLR = 1'b1;
        COUNT_IN = 4'd3;
        step(1);
        CLR = 1'b0;
        goto_tick();
        check("first_tick_valid", int'(VALID), 0);
        COUNT_IN = 4'd7;
        exp_q.push_back(4);
        goto_tick();
        check("tick2_valid", int'(VALID), 1);
        accept();
        check("valid_cleared", int'(VALID), 0);

        // Wrap: baseline 14, then 2 -> 4.
        COUNT_IN = 4'd14;
        exp_q.push_back(7);
        goto_tick();
        accept();
        COUNT_IN = 4'd2;
        exp_q.push_back(4);
        goto_tick();
        accept();

        // Glitch rejection around a stable 5.
        COUNT_IN = 4'd5;
        exp_q.push_back(3);
        goto_tick();
        accept();
        step(3);
        COUNT_IN = 4'd9;
        step(1);
        COUNT_IN = 4'd5;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("glitch_filt", int'(FILT_COUNT), 5);
        end
        exp_q.push_back(0);
        goto_tick();
        accept();

        // Backpressure: baseline 3, then 6 (kept), 10 (dropped), 12.
        COUNT_IN = 4'd3;
        exp_q.push_back(14);
        goto_tick();
        accept();
        COUNT_IN = 4'd6;
        exp_q.push_back(3);
        goto_tick();
        check("bp_valid", int'(VALID), 1);
        check("bp_no_overrun", int'(OVERRUN), 0);
        COUNT_IN = 4'd10;
        goto_tick();
        check("bp_overrun", int'(OVERRUN), 1);
        check("bp_delta_held", int'(DELTA), 3);
        COUNT_IN = 4'd12;
        exp_q.push_back(2);
        goto_phase(PER - 1);
        accept();
        check("coincident_valid", int'(VALID), 1);
        check("coincident_overrun", int'(OVERRUN), 1);
        accept();

        // Reset mid-operation with a pending result and OVERRUN set.
        COUNT_IN = 4'd15;
        goto_tick();
        check("pre_clr_valid", int'(VALID), 1);
        CLR = 1'b1;
        step(1);
        CLR = 1'b0;
        check("clr_valid",   int'(VALID), 0);
        check("clr_delta",   int'(DELTA), 0);
        check("clr_filt",    int'(FILT_COUNT), 0);
        check("clr_overrun", int'(OVERRUN), 0);
        goto_tick();
        check("after_clr_first_tick", int'(VALID), 0);
        check("after_clr_filt", int'(FILT_COUNT), 15);

        step(2);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
